mc_cu: RTL

- Multicycle control unit for the team's MIPS subset. It reuses the single-cycle decode set (add sub and or xor sll srl sra jr addi andi ori xori lw sw beq bne lui j jal).
- It sequences a shared-ALU, single-memory multicycle datapath through IF/ID/EXE/MEM/WB states.
- It drives the register write enables (PC, IR, regfile, memory), the datapath mux selects and the ALU op.
- Sits beside mccpu's datapath. It replaces the combinational single-cycle controller when instruction and data memory are merged.

---
 rtl/mc_cu.sv | 108 ++++++++++
 1 files changed

// File: rtl/mc_cu.sv
// mc_cu: multicycle MIPS-subset control unit sequencing IF/ID/EXE/MEM/WB for a shared-ALU datapath
module mc_cu (
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic [3:0] aluc,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic [1:0] pcsource,
  output logic       jal,
  output logic [2:0] state
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  state_t cur, nxt;
  logic r, i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic i_imm, i_ls, br, jmp, valid;
  assign r      = op == 6'b000000;
  assign i_add  = r & (func == 6'b100000);
  assign i_sub  = r & (func == 6'b100010);
  assign i_and  = r & (func == 6'b100100);
  assign i_or   = r & (func == 6'b100101);
  assign i_xor  = r & (func == 6'b100110);
  assign i_sll  = r & (func == 6'b000000);
  assign i_srl  = r & (func == 6'b000010);
  assign i_sra  = r & (func == 6'b000011);
  assign i_jr   = r & (func == 6'b001000);
  assign i_addi = op == 6'b001000;
  assign i_andi = op == 6'b001100;
  assign i_ori  = op == 6'b001101;
  assign i_xori = op == 6'b001110;
  assign i_lui  = op == 6'b001111;
  assign i_lw   = op == 6'b100011;
  assign i_sw   = op == 6'b101011;
  assign i_beq  = op == 6'b000100;
  assign i_bne  = op == 6'b000101;
  assign i_j    = op == 6'b000010;
  assign i_jal  = op == 6'b000011;
  assign i_imm  = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign i_ls   = i_lw | i_sw;
  assign br     = i_beq | i_bne;
  assign jmp    = i_j | i_jal | i_jr;
  assign valid  = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra
                | jmp | i_imm | i_ls | br;
  assign state  = cur;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cur <= S_IF;
    else cur <= nxt;
  always_comb begin
    nxt = S_IF;
    {wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, sext, jal} = '0;
    aluc = 4'b0000;
    alusrcb = 2'b00;
    pcsource = 2'b00;
    case (cur)
      S_IF: begin
        wir = 1'b1;
        wpc = 1'b1;
        alusrcb = 2'b01;
        nxt = S_ID;
      end
      S_ID: begin
        alusrcb = 2'b11;
        sext = 1'b1;
        wpc = jmp;
        pcsource = i_jr ? 2'b10 : (i_j | i_jal) ? 2'b11 : 2'b00;
        jal = i_jal;
        wreg = i_jal;
        nxt = (jmp | ~valid) ? S_IF : S_EXE;
      end
      S_EXE: begin
        alusrca = 1'b1;
        alusrcb = (i_imm | i_ls) ? 2'b10 : 2'b00;
        sext = i_addi | i_ls;
        shift = i_sll | i_srl | i_sra;
        aluc = (i_sub | br) ? 4'b0100 : (i_and | i_andi) ? 4'b0001 : (i_or | i_ori) ? 4'b0101 :
               (i_xor | i_xori) ? 4'b0010 : i_lui ? 4'b0110 : i_sll ? 4'b0011 :
               i_srl ? 4'b0111 : i_sra ? 4'b1111 : 4'b0000;
        pcsource = br ? 2'b01 : 2'b00;
        wpc = (i_beq & z) | (i_bne & ~z);
        nxt = i_ls ? S_MEM : br ? S_IF : S_WB;
      end
      S_MEM: begin
        iord = 1'b1;
        wmem = i_sw;
        nxt = i_lw ? S_WB : S_IF;
      end
      S_WB: begin
        wreg = 1'b1;
        regrt = i_imm | i_lw;
        m2reg = i_lw;
      end
      default: ;
    endcase
    if (!resetn) {wpc, wir, wmem, wreg} = '0;
  end
endmodule
